// File: rtl/xge_mac_reg_master.sv
// xge_mac_reg_master
// Register-bus initiator for the xge_mac register block. It accepts one read
// or write on a valid/ready command port and issues it as a one-cycle
// regb_wen_o/regb_ren_o pulse. It then waits for an ack, or times out, and
// returns one response. Only one transaction is in flight at a time.
// Optional feature: define XGE_MAC_REG_MASTER_RETRY_EN to re-issue a command
// after a responder error, up to MAX_RETRY times. Timeouts are never retried.
module xge_mac_reg_master #(
    parameter int REG_ADDR_WIDTH = 32,
    parameter int REG_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int MAX_RETRY      = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid_i,
    output logic                      cmd_ready_o,
    input  logic                      cmd_write_i,
    input  logic [REG_ADDR_WIDTH-1:0] cmd_addr_i,
    input  logic [REG_DATA_WIDTH-1:0] cmd_wdata_i,
    output logic                      rsp_valid_o,
    input  logic                      rsp_ready_i,
    output logic [REG_DATA_WIDTH-1:0] rsp_rdata_o,
    output logic                      rsp_error_o,
    output logic                      rsp_timeout_o,
    output logic                      busy_o,
    output logic [REG_ADDR_WIDTH-1:0] regb_addr_o,
    output logic [REG_DATA_WIDTH-1:0] regb_wbdata_o,
    output logic                      regb_wen_o,
    output logic                      regb_ren_o,
    input  logic [REG_DATA_WIDTH-1:0] regb_rdata_i,
    input  logic                      regb_ack_i,
    input  logic                      regb_error_i
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    // Last WAIT cycle in which an ack is still accepted.
    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]                state_r;
    logic [1:0]                state_nxt_s;
    logic                      accept_s;
    logic                      issue_write_s;
    logic                      timeout_hit_s;
    logic                      write_r;
    logic [REG_ADDR_WIDTH-1:0] addr_r;
    logic [REG_DATA_WIDTH-1:0] wdata_r;
    logic [7:0]                timer_r;
    logic                      cmd_ready_r;
    logic                      busy_r;
    logic                      rsp_valid_r;
    logic                      wen_r;
    logic                      ren_r;
    logic [REG_DATA_WIDTH-1:0] rsp_rdata_r;
    logic                      rsp_error_r;
    logic                      rsp_timeout_r;

`ifdef XGE_MAC_REG_MASTER_RETRY_EN
    localparam logic [2:0] RETRY_LIMIT = 3'(MAX_RETRY);
    logic [2:0] retry_cnt_r;
    logic       retry_s;
`endif

    assign accept_s      = (state_r == IDLE) && cmd_valid_i;
    // A re-issue keeps the captured direction; a fresh accept uses the port.
    assign issue_write_s = accept_s ? cmd_write_i : write_r;
    assign timeout_hit_s = (timer_r == TIMER_LAST);

    // Next-state decode; ack is only looked at while waiting for it.
    always_comb begin
        state_nxt_s = state_r;
`ifdef XGE_MAC_REG_MASTER_RETRY_EN
        retry_s = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_nxt_s = ISSUE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ISSUE: begin
                state_nxt_s = WAIT;
            end
            WAIT: begin
                if (regb_ack_i) begin
`ifdef XGE_MAC_REG_MASTER_RETRY_EN
                    if (regb_error_i && (retry_cnt_r < RETRY_LIMIT)) begin
                        retry_s     = 1'b1;
                        state_nxt_s = ISSUE;
                    end else begin
                        state_nxt_s = RESP;
                    end
`else
                    state_nxt_s = RESP;
`endif
                end else if (timeout_hit_s) begin
                    state_nxt_s = RESP;
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // State register plus status/strobe outputs registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            cmd_ready_r <= 1'b1;
            busy_r      <= 1'b0;
            rsp_valid_r <= 1'b0;
            wen_r       <= 1'b0;
            ren_r       <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            cmd_ready_r <= (state_nxt_s == IDLE);
            busy_r      <= (state_nxt_s != IDLE);
            rsp_valid_r <= (state_nxt_s == RESP);
            wen_r       <= (state_nxt_s == ISSUE) && issue_write_s;
            ren_r       <= (state_nxt_s == ISSUE) && !issue_write_s;
        end
    end

    // Capture the command on accept; it drives the bus until the next accept.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
        end else if (accept_s) begin
            write_r <= cmd_write_i;
            addr_r  <= cmd_addr_i;
            wdata_r <= cmd_wdata_i;
        end else begin
            write_r <= write_r;
            addr_r  <= addr_r;
            wdata_r <= wdata_r;
        end
    end

    // Ack timer: cleared on each issue, counts every cycle spent waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_r <= 8'd0;
        end else if (state_r == ISSUE) begin
            timer_r <= 8'd0;
        end else if (state_r == WAIT) begin
            timer_r <= timer_r + 8'd1;
        end else begin
            timer_r <= timer_r;
        end
    end

`ifdef XGE_MAC_REG_MASTER_RETRY_EN
    // Retry counter: cleared per command, bumped on each error-driven re-issue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retry_cnt_r <= 3'd0;
        end else if (accept_s) begin
            retry_cnt_r <= 3'd0;
        end else if (retry_s) begin
            retry_cnt_r <= retry_cnt_r + 3'd1;
        end else begin
            retry_cnt_r <= retry_cnt_r;
        end
    end
`endif

    // Response fields: loaded on entry to RESP, held until the handshake.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_rdata_r   <= '0;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if (accept_s) begin
            rsp_rdata_r   <= '0;
            rsp_error_r   <= 1'b0;
            rsp_timeout_r <= 1'b0;
        end else if ((state_r == WAIT) && (state_nxt_s == RESP)) begin
            if (regb_ack_i) begin
                rsp_error_r   <= regb_error_i;
                rsp_timeout_r <= 1'b0;
                rsp_rdata_r   <= (!write_r && !regb_error_i) ? regb_rdata_i : '0;
            end else begin
                rsp_error_r   <= 1'b1;
                rsp_timeout_r <= 1'b1;
                rsp_rdata_r   <= '0;
            end
        end else begin
            rsp_rdata_r   <= rsp_rdata_r;
            rsp_error_r   <= rsp_error_r;
            rsp_timeout_r <= rsp_timeout_r;
        end
    end

    assign cmd_ready_o   = cmd_ready_r;
    assign busy_o        = busy_r;
    assign rsp_valid_o   = rsp_valid_r;
    assign rsp_rdata_o   = rsp_rdata_r;
    assign rsp_error_o   = rsp_error_r;
    assign rsp_timeout_o = rsp_timeout_r;
    assign regb_addr_o   = addr_r;
    assign regb_wbdata_o = wdata_r;
    assign regb_wen_o    = wen_r;
    assign regb_ren_o    = ren_r;

endmodule

// File: tb/tb_xge_mac_reg_master.sv
// Directed bench for xge_mac_reg_master. A small register-block responder
// acks one cycle after each strobe (0x0 reads 0x4, 0x4 is a scratch
// register, every other address errors). A stub mode silences it so
// timeouts can be provoked, and an injected ack can be placed in any cycle.
module tb_xge_mac_reg_master;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = 32'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_error;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] regb_addr;
    logic [31:0] regb_wbdata;
    logic        regb_wen;
    logic        regb_ren;
    logic [31:0] regb_rdata;
    logic        regb_ack;
    logic        regb_error;

    logic        stub_mode = 1'b0;
    logic        inject_ack = 1'b0;
    logic [31:0] inject_rdata = 32'h5A5A_0001;

    int tests = 0;
    int failed = 0;
    int ren_count = 0;

    always #5 clk = ~clk;

    xge_mac_reg_master dut (
        .clk           (clk),
        .reset         (reset),
        .cmd_valid_i   (cmd_valid),
        .cmd_ready_o   (cmd_ready),
        .cmd_write_i   (cmd_write),
        .cmd_addr_i    (cmd_addr),
        .cmd_wdata_i   (cmd_wdata),
        .rsp_valid_o   (rsp_valid),
        .rsp_ready_i   (rsp_ready),
        .rsp_rdata_o   (rsp_rdata),
        .rsp_error_o   (rsp_error),
        .rsp_timeout_o (rsp_timeout),
        .busy_o        (busy),
        .regb_addr_o   (regb_addr),
        .regb_wbdata_o (regb_wbdata),
        .regb_wen_o    (regb_wen),
        .regb_ren_o    (regb_ren),
        .regb_rdata_i  (regb_rdata),
        .regb_ack_i    (regb_ack),
        .regb_error_i  (regb_error)
    );

    // Responder model, reset by the inverse of the master's reset.
    logic        rst_n;
    logic        rb_ack;
    logic        rb_err;
    logic [31:0] rb_rdata;
    logic [31:0] scratch;
    assign rst_n = ~reset;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rb_ack   <= 1'b0;
            rb_err   <= 1'b0;
            rb_rdata <= 32'd0;
            scratch  <= 32'd0;
        end else begin
            rb_ack   <= 1'b0;
            rb_err   <= 1'b0;
            rb_rdata <= 32'd0;
            if (!stub_mode && (regb_wen || regb_ren)) begin
                rb_ack <= 1'b1;
                case (regb_addr)
                    32'h0: rb_rdata <= regb_ren ? 32'h4 : 32'h0;
                    32'h4: begin
                        if (regb_wen) scratch <= regb_wbdata;
                        else rb_rdata <= scratch;
                    end
                    default: rb_err <= 1'b1;
                endcase
            end
        end
    end

    assign regb_ack   = rb_ack | inject_ack;
    assign regb_error = inject_ack ? 1'b0 : rb_err;
    assign regb_rdata = inject_ack ? inject_rdata : rb_rdata;

    // Count read strobes so retries can be observed.
    always_ff @(posedge clk) begin
        ren_count <= ren_count + (regb_ren ? 1 : 0);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One full command: accept, strobe, wait (bounded) for response, consume.
    // lat is the cycle index of rsp_valid counted from the accept cycle T.
    task automatic run_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input int inject_at, output logic [31:0] rdata,
                           output logic err, output logic to, output int lat);
        chk("cmd_ready_before_accept", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        step;
        cmd_valid = 1'b0;
        chk("strobe_at_t1", {30'd0, regb_wen, regb_ren}, wr ? 32'd2 : 32'd1);
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            inject_ack = (lat == inject_at);
            step;
            lat++;
        end
        inject_ack = 1'b0;
        rdata = rsp_rdata;
        err   = rsp_error;
        to    = rsp_timeout;
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk("ready_after_handshake", {30'd0, cmd_ready, rsp_valid}, 32'd2);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [31:0] rd;
        logic        er;
        logic        tmo;
        int          lat;
        int          ren_base;
        logic        seen_valid;

        step;
        step;
        chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
        chk("reset_outputs", {26'd0, rsp_valid, rsp_error, rsp_timeout, busy, regb_wen, regb_ren}, 32'd0);
        chk("reset_regb_addr", regb_addr, 32'd0);
        reset = 1'b0;
        step;

        // Read of the ID register straight after reset.
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, tmo, lat);
        chk("read0_rdata", rd, 32'h4);
        chk("read0_err_to", {30'd0, er, tmo}, 32'd0);
        chk("read0_latency", lat, 32'd3);

        // Write then read back the scratch register.
        run_cmd(1'b1, 32'h4, 32'hDEADBEEF, 0, rd, er, tmo, lat);
        chk("write4_rdata", rd, 32'h0);
        chk("write4_err", {31'd0, er}, 32'd0);
        chk("write4_latency", lat, 32'd3);
        run_cmd(1'b0, 32'h4, 32'h0, 0, rd, er, tmo, lat);
        chk("read4_rdata", rd, 32'hDEADBEEF);
        chk("read4_err", {31'd0, er}, 32'd0);
        chk("read4_latency", lat, 32'd3);

        // Unmapped read: responder error.
        ren_base = ren_count;
        run_cmd(1'b0, 32'hC, 32'h0, 0, rd, er, tmo, lat);
        chk("readc_err_to", {30'd0, er, tmo}, 32'd2);
        chk("readc_rdata", rd, 32'h0);
`ifdef XGE_MAC_REG_MASTER_RETRY_EN
        chk("readc_ren_pulses", ren_count - ren_base, 32'd3);
        chk("readc_latency", lat, 32'd7);
`else
        chk("readc_ren_pulses", ren_count - ren_base, 32'd1);
        chk("readc_latency", lat, 32'd3);
`endif

        // Response backpressure with the next command already waiting.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h4;
        step;
        cmd_valid = 1'b0;
        step;
        step;
        chk("bp_rsp_valid_t3", {31'd0, rsp_valid}, 32'd1);
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = 32'h4;
        cmd_wdata = 32'h12345678;
        for (int i = 0; i < 5; i++) begin
            chk("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            chk("bp_hold_flags", {26'd0, rsp_valid, cmd_ready, rsp_error, rsp_timeout, regb_wen, regb_ren}, 32'h20);
            chk("bp_hold_addr", regb_addr, 32'h4);
            step;
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        chk("bp_ready_after_hs", {30'd0, cmd_ready, rsp_valid}, 32'd2);
        step;
        cmd_valid = 1'b0;
        chk("bp_next_accepted", {30'd0, regb_wen, regb_ren}, 32'd2);
        step;
        step;
        chk("bp_next_rsp", {30'd0, rsp_valid, rsp_error}, 32'd2);
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        run_cmd(1'b0, 32'h4, 32'h0, 0, rd, er, tmo, lat);
        chk("bp_readback", rd, 32'h12345678);

        // Silent responder: timeout.
        stub_mode = 1'b1;
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, tmo, lat);
        chk("timeout_latency", lat, 32'd18);
        chk("timeout_err_to", {30'd0, er, tmo}, 32'd3);
        chk("timeout_rdata", rd, 32'h0);

        // Ack in the last timeout cycle wins.
        run_cmd(1'b0, 32'h0, 32'h0, 17, rd, er, tmo, lat);
        chk("lastack_latency", lat, 32'd18);
        chk("lastack_err_to", {30'd0, er, tmo}, 32'd0);
        chk("lastack_rdata", rd, 32'h5A5A_0001);

        // Ack during ISSUE is ignored, so the command still times out.
        run_cmd(1'b0, 32'h0, 32'h0, 1, rd, er, tmo, lat);
        chk("issueack_latency", lat, 32'd18);
        chk("issueack_err_to", {30'd0, er, tmo}, 32'd3);

        // Reset while waiting drops the command.
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        step;
        cmd_valid = 1'b0;
        step;
        chk("wait_busy", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        chk("async_reset_flags", {26'd0, cmd_ready, busy, rsp_valid, regb_wen, regb_ren, rsp_error}, 32'h20);
        chk("async_reset_addr", regb_addr, 32'd0);
        step;
        step;
        reset = 1'b0;
        stub_mode = 1'b0;
        seen_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            seen_valid = seen_valid | rsp_valid;
            step;
        end
        chk("no_rsp_after_reset", {31'd0, seen_valid}, 32'd0);
        run_cmd(1'b0, 32'h0, 32'h0, 0, rd, er, tmo, lat);
        chk("post_reset_rdata", rd, 32'h4);
        chk("post_reset_latency", lat, 32'd3);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
